pattern_hflipper: RTL and testbench

Horizontal-flip unit for one background/sprite pattern line: 8 pixels of 2-bit colour index packed into 16 bits. It sits between pattern memory (PMB) and the background scanline memory. One instance per nametable column.
- Zero-latency combinational path: used by the scanline fill logic.
- Registered copy with valid: for pipelined consumers.

---
 rtl/pattern_hflipper_pkg.sv | 24 ++
 rtl/pattern_hflipper_pixel_reverse_comb.sv | 39 +++
 rtl/pattern_hflipper.sv | 58 +++++
 tb/tb_pattern_hflipper.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_hflipper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_hflipper_pkg
//  Description : Shared GPU pattern-line parameters and the pixel-field
//                index helper used by the horizontal-flip logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_hflipper_pkg;

    // Pixels in one tile/sprite pattern line.
    localparam int PIXELS_PER_TILE = 8;
    // Colour-index width of one pixel.
    localparam int BPP             = 2;
    // Packed width of one pattern line.
    localparam int PATTERN_LINE_W  = PIXELS_PER_TILE * BPP;

    // Bit offset of the LSB of pixel i. Pixel 0 (leftmost) sits in the most
    // significant field, so the offset counts down as i increases.
    function automatic int field_offset(input int i, input int pixels, input int bpp);
        return (pixels - 1 - i) * bpp;
    endfunction

endpackage : pattern_hflipper_pkg
`default_nettype wire

// File: rtl/pattern_hflipper_pixel_reverse_comb.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_reverse_comb
//  Description : Purely combinational horizontal mirror of one packed
//                pattern line. Whole BPP-bit fields are swapped end for end;
//                the bit order inside each pixel is left untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_reverse_comb #(
    parameter  int PIXELS = 8,
    parameter  int BPP    = 2,
    localparam int LINE_W = PIXELS * BPP
) (
    input  logic [LINE_W-1:0] pattern,
    input  logic              hflip,
    output logic [LINE_W-1:0] line
);
    import pattern_hflipper_pkg::*;

    logic [LINE_W-1:0] w_reversed;

    // Output pixel i takes input pixel PIXELS-1-i, moved as an entire field.
    generate
        for (genvar i = 0; i < PIXELS; i++) begin : g_pixel
            assign w_reversed[field_offset(i, PIXELS, BPP) +: BPP] =
                pattern[field_offset(PIXELS - 1 - i, PIXELS, BPP) +: BPP];
        end
    endgenerate

    // Select mirrored or pass-through line.
    always_comb begin
        line = pattern;
        if (hflip) begin
            line = w_reversed;
        end
    end

endmodule : pixel_reverse_comb
`default_nettype wire

// File: rtl/pattern_hflipper.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_hflipper
//  Description : Horizontal-flip unit for one pattern line between pattern
//                memory and the background scanline memory. Provides a
//                zero-latency combinational result and a one-cycle
//                registered copy qualified by valid_q.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_hflipper #(
    parameter  int PIXELS = pattern_hflipper_pkg::PIXELS_PER_TILE,
    parameter  int BPP    = pattern_hflipper_pkg::BPP,
    localparam int LINE_W = PIXELS * BPP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] pattern,
    input  logic              hflip,
    output logic [LINE_W-1:0] line,
    input  logic              in_valid,
    output logic [LINE_W-1:0] line_q,
    output logic              valid_q
);
    import pattern_hflipper_pkg::*;

    logic [LINE_W-1:0] w_line;
    logic [LINE_W-1:0] r_line;
    logic              r_valid;

    // Single shared field-reversal network feeds both output paths.
    pixel_reverse_comb #(
        .PIXELS (PIXELS),
        .BPP    (BPP)
    ) u_reverse (
        .pattern (pattern),
        .hflip   (hflip),
        .line    (w_line)
    );

    assign line = w_line;

    // Registered copy: the data register loads every cycle independent of
    // in_valid, so an unknown in_valid can never reach line_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_line  <= w_line;
            r_valid <= in_valid;
        end
    end

    assign line_q  = r_line;
    assign valid_q = r_valid;

endmodule : pattern_hflipper
`default_nettype wire

// File: tb/tb_pattern_hflipper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_hflipper
//  Description : Self-checking bench for pattern_hflipper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_hflipper;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pattern;
    logic        hflip;
    logic [15:0] line;
    logic        in_valid;
    logic [15:0] line_q;
    logic        valid_q;

    // Second instance with 4 pixels of 4 bits.
    logic [15:0] p4_pattern;
    logic        p4_hflip;
    logic [15:0] p4_line;
    logic [15:0] p4_line_q;
    logic        p4_valid_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pattern_hflipper dut (
        .clk      (clk),
        .rst      (rst),
        .pattern  (pattern),
        .hflip    (hflip),
        .line     (line),
        .in_valid (in_valid),
        .line_q   (line_q),
        .valid_q  (valid_q)
    );

    pattern_hflipper #(.PIXELS(4), .BPP(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .pattern  (p4_pattern),
        .hflip    (p4_hflip),
        .line     (p4_line),
        .in_valid (1'b1),
        .line_q   (p4_line_q),
        .valid_q  (p4_valid_q)
    );

    // Reference: unpack into a pixel array, mirror the array, repack.
    function automatic logic [15:0] ref_flip(input logic [15:0] p, input logic h);
        logic [1:0]  px [8];
        logic [15:0] o;
        for (int i = 0; i < 8; i++) px[i] = 2'((p >> (14 - 2 * i)) & 16'h3);
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o = o | (16'(h ? px[7 - i] : px[i]) << (14 - 2 * i));
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] pat;
        logic        flip;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [15:0] exp_prev;
        logic        vld_prev;
        logic [15:0] first;

        vecs[0] = '{16'h1B00, 1'b0, 16'h1B00};
        vecs[1] = '{16'h1B00, 1'b1, 16'h00E4};
        vecs[2] = '{16'h8000, 1'b1, 16'h0002};
        vecs[3] = '{16'h4000, 1'b1, 16'h0001};
        vecs[4] = '{16'hFFFF, 1'b1, 16'hFFFF};
        vecs[5] = '{16'h0000, 1'b1, 16'h0000};
        vecs[6] = '{16'h8002, 1'b1, 16'h8002};
        vecs[7] = '{16'hC000, 1'b1, 16'h0003};
        vecs[8] = '{16'h1234, 1'b1, 16'h1C84};
        vecs[9] = '{16'h1234, 1'b0, 16'h1234};

        rst        = 1'b1;
        pattern    = 16'h0000;
        hflip      = 1'b0;
        in_valid   = 1'b0;
        p4_pattern = 16'h1234;
        p4_hflip   = 1'b1;

        // Reset state.
        @(posedge clk); #1;
        check("reset_line_q", line_q, 16'h0000);
        check("reset_valid_q", {15'd0, valid_q}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Generic widths: 4 pixels x 4 bits.
        #1;
        check("p4_flip", p4_line, 16'h4321);
        p4_hflip = 1'b0;
        #1;
        check("p4_pass", p4_line, 16'h1234);

        // Table vectors: combinational then registered.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pattern  = vecs[k].pat;
            hflip    = vecs[k].flip;
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_line", k), line, vecs[k].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d_line_q", k), line_q, vecs[k].exp);
            check($sformatf("vec%0d_valid_q", k), {15'd0, valid_q}, 16'h0001);
        end

        // Exhaustive combinational sweep, both hflip values.
        for (int h = 0; h < 2; h++) begin
            for (int p = 0; p < 65536; p++) begin
                pattern = 16'(p);
                hflip   = h[0];
                #1;
                check("sweep", line, ref_flip(16'(p), h[0]));
            end
        end

        // Flipping twice returns the original.
        for (int k = 0; k < 64; k++) begin
            first   = 16'($urandom);
            pattern = first;
            hflip   = 1'b1;
            #1;
            pattern = line;
            #1;
            check("double_flip", line, first);
        end

        // Random registered traffic against the model.
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            pattern  = 16'($urandom);
            hflip    = 1'($urandom);
            in_valid = 1'($urandom);
            exp_prev = ref_flip(pattern, hflip);
            vld_prev = in_valid;
            @(posedge clk); #1;
            check("rand_line_q", line_q, exp_prev);
            check("rand_valid_q", {15'd0, valid_q}, {15'd0, vld_prev});
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle.
        pattern  = 16'hABCD;
        hflip    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_line_q", line_q, 16'hABCD);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_line_q", line_q, 16'h0000);
        check("async_rst_valid_q", {15'd0, valid_q}, 16'h0000);
        check("async_rst_line", line, 16'hABCD);
        @(posedge clk); #1;
        check("held_rst_line_q", line_q, 16'h0000);
        check("held_rst_valid_q", {15'd0, valid_q}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("released_before_edge", {15'd0, valid_q}, 16'h0000);
        @(posedge clk); #1;
        check("post_rst_line_q", line_q, 16'hABCD);
        check("post_rst_valid_q", {15'd0, valid_q}, 16'h0001);

        // hflip toggling every cycle.
        @(negedge clk);
        pattern  = 16'hC000;
        in_valid = 1'b1;
        hflip    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("toggle_line_q", line_q, (k % 2 == 0) ? 16'hC000 : 16'h0003);
            check("toggle_valid_q", {15'd0, valid_q}, 16'h0001);
            @(negedge clk);
            hflip = ~hflip;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pattern_hflipper
`default_nettype wire
